sram_arbiter: RTL and testbench

Shares the single 16-bit asynchronous SRAM between the display read path (framebuffer scan-out) and a pixel write path (trace/drawing engine). It replaces the alternating-cycle bus split and the standalone SRAM clear pass, and owns all SRAM pins. Every access is a fixed two-cycle transaction at 50 MHz. Reads win by default, and a bounded read streak guarantees the writer forward progress.

---
 rtl/sram_arbiter_if.sv | 27 ++
 rtl/sram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for sram_arbiter: display read port, pixel write port
// and the init_done status flag.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [15:0]       rd_data;
  logic              rd_valid;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [1:0]        wr_be;
  logic              wr_gnt;
  logic              init_done;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, rd_valid, wr_gnt, init_done
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, rd_valid, wr_gnt, init_done
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-cycle-per-access arbiter owning the async SRAM pins; reads win, bounded read streak.
// Define SRAM_ARB_CLEAR_EN to add the post-reset clear sweep (CLR_A/CLR_B) gating init_done.
module sram_arbiter #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned MAX_RD_BURST = 4,
  parameter logic [15:0] CLEAR_WORD   = 16'h0000
) (
  input  logic              clk50,
  input  logic              rst,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [15:0]       SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam logic [3:0] BURST = 4'(MAX_RD_BURST);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    WR_A,
    WR_B
`ifdef SRAM_ARB_CLEAR_EN
    , CLR_A
    , CLR_B
`endif
  } state_t;

  state_t      state;
  logic [3:0]  rd_streak;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        rd_gnt_q;
  logic        wr_gnt_q;
  logic        rd_valid_q;
  logic [15:0] rd_data_q;
  logic        ready;
  logic        at_dec;
  logic        go_rd;
  logic        go_wr;

`ifdef SRAM_ARB_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;
  logic              go_clr;
  logic              sweep_end;
`else
  assign ready = 1'b1;
`endif

  assign SRAM_DQ       = dq_oe ? dq_out : 'z;
  assign bus.rd_gnt    = rd_gnt_q;
  assign bus.wr_gnt    = wr_gnt_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.init_done = ready;

  always_comb begin
    at_dec = (state == IDLE) || (state == RD_B) || (state == WR_B);
    go_rd  = 1'b0;
    go_wr  = 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
    at_dec    = at_dec || (state == CLR_B);
    // clr_addr has wrapped to 0 once the last word has been issued
    sweep_end = (state == CLR_B) && (clr_addr == '0);
    go_clr    = 1'b0;
`endif
    if (at_dec) begin
`ifdef SRAM_ARB_CLEAR_EN
      if (!ready) go_clr = !sweep_end;
      else
`endif
      if (bus.rd_req && bus.wr_req) begin
        if (rd_streak == BURST) go_wr = 1'b1;
        else                    go_rd = 1'b1;
      end else if (bus.rd_req) begin
        go_rd = 1'b1;
      end else if (bus.wr_req) begin
        go_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state      <= IDLE;
      SRAM_ADDR  <= '0;
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_UB_N  <= 1'b1;
      SRAM_LB_N  <= 1'b1;
      dq_out     <= CLEAR_WORD;
      dq_oe      <= 1'b0;
      rd_gnt_q   <= 1'b0;
      wr_gnt_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_streak  <= '0;
`ifdef SRAM_ARB_CLEAR_EN
      ready      <= 1'b0;
      clr_addr   <= '0;
`endif
    end else begin
      rd_gnt_q   <= 1'b0;
      wr_gnt_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      if (state == RD_B) begin
        rd_data_q  <= SRAM_DQ;
        rd_valid_q <= 1'b1;
      end
      if (at_dec) begin
        if (!bus.wr_req || go_wr)             rd_streak <= '0;
        else if (go_rd && rd_streak != BURST) rd_streak <= rd_streak + 4'd1;
        state     <= IDLE;
        SRAM_CE_N <= 1'b1;
        SRAM_OE_N <= 1'b1;
        SRAM_WE_N <= 1'b1;
        SRAM_UB_N <= 1'b1;
        SRAM_LB_N <= 1'b1;
        dq_oe     <= 1'b0;
        if (go_rd) begin
          state     <= RD_A;
          SRAM_ADDR <= bus.rd_addr;
          SRAM_CE_N <= 1'b0;
          SRAM_OE_N <= 1'b0;
          SRAM_UB_N <= 1'b0;
          SRAM_LB_N <= 1'b0;
          rd_gnt_q  <= 1'b1;
        end else if (go_wr) begin
          state     <= WR_A;
          SRAM_ADDR <= bus.wr_addr;
          SRAM_CE_N <= 1'b0;
          SRAM_WE_N <= 1'b0;
          SRAM_UB_N <= ~bus.wr_be[1];
          SRAM_LB_N <= ~bus.wr_be[0];
          dq_out    <= bus.wr_data;
          dq_oe     <= 1'b1;
          wr_gnt_q  <= 1'b1;
        end
`ifdef SRAM_ARB_CLEAR_EN
        else if (go_clr) begin
          state     <= CLR_A;
          SRAM_ADDR <= clr_addr;
          SRAM_CE_N <= 1'b0;
          SRAM_WE_N <= 1'b0;
          SRAM_UB_N <= 1'b0;
          SRAM_LB_N <= 1'b0;
          dq_out    <= CLEAR_WORD;
          dq_oe     <= 1'b1;
          clr_addr  <= clr_addr + ADDR_W'(1);
        end
        if (sweep_end) ready <= 1'b1;
`endif
      end else begin
        // second half of an access: WE_N rises while address/data/CE_N stay put for hold
        case (state)
          RD_A: state <= RD_B;
          WR_A: begin
            state     <= WR_B;
            SRAM_WE_N <= 1'b1;
          end
`ifdef SRAM_ARB_CLEAR_EN
          CLR_A: begin
            state     <= CLR_B;
            SRAM_WE_N <= 1'b1;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: pin-level SRAM model, vector table, hand sequences and a
// randomized reader/writer pair scored against a shadow memory.
module tb_sram_arbiter;
  localparam int unsigned AW    = 4;
  localparam int unsigned BURST = 4;
  localparam logic [15:0] PROBE = 16'hA5C3;

  logic clk50 = 1'b0;
  logic rst   = 1'b1;
  always #10 clk50 = ~clk50;

  sram_arbiter_if #(.ADDR_W(AW)) bus ();

  logic [AW-1:0] sram_addr;
  wire  [15:0]   sram_dq;
  logic ce_n, oe_n, we_n, ub_n, lb_n;

  sram_arbiter #(.ADDR_W(AW), .MAX_RD_BURST(BURST), .CLEAR_WORD(16'h0000)) dut (
    .clk50     (clk50),
    .rst       (rst),
    .bus       (bus),
    .SRAM_ADDR (sram_addr),
    .SRAM_DQ   (sram_dq),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n),
    .SRAM_WE_N (we_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n)
  );

  // Async SRAM model; drives PROBE while deselected so an undriven bus is recognisable.
  logic [15:0]   mem    [16];
  logic [15:0]   shadow [16];
  logic [AW-1:0] log_addr [$];
  logic [15:0]   log_data [$];
  logic          tb_en;
  logic [15:0]   tb_val;

  always_comb begin
    tb_en  = ce_n || (!oe_n && we_n);
    tb_val = ce_n ? PROBE : mem[sram_addr];
  end
  assign sram_dq = tb_en ? tb_val : 'z;

  always @(posedge we_n) begin
    if (!ce_n) begin
      if (!ub_n) mem[sram_addr][15:8] = sram_dq[15:8];
      if (!lb_n) mem[sram_addr][7:0]  = sram_dq[7:0];
      log_addr.push_back(sram_addr);
      log_data.push_back(sram_dq);
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void shadow_write(input logic [AW-1:0] a, input logic [15:0] d,
                                       input logic [1:0] be);
    if (be[1]) shadow[a][15:8] = d[15:8];
    if (be[0]) shadow[a][7:0]  = d[7:0];
  endfunction

  task automatic do_write(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be,
                          input bit bounded);
    int n = 0;
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
    @(negedge clk50);
    while (!bus.wr_gnt && n < 40) begin
      @(negedge clk50);
      n++;
    end
    check("wr_gnt_seen", 32'(n < 40), 1);
    bus.wr_req = 1'b0;
    if (n < 40) begin
      shadow_write(a, d, be);
      if (bounded) check("wr_wait_bound", 32'(n + 1 <= 2 * (BURST + 1)), 1);
      check("wr_a_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, {3'b010, ~be});
      check("wr_a_addr", sram_addr, a);
      check("wr_a_dq", sram_dq, d);
      @(negedge clk50);
      check("wr_b_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, {3'b011, ~be});
      check("wr_b_dq_hold", sram_dq, d);
      check("wr_gnt_pulse", bus.wr_gnt, 0);
      @(negedge clk50);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [15:0] exp, input bit solo);
    int n = 0, vcnt = 0, vat = -1, oe = 0;
    logic [15:0] got = '0;
    logic [15:0] want;
    bus.rd_req = 1'b1; bus.rd_addr = a;
    @(negedge clk50);
    while (!bus.rd_gnt && n < 40) begin
      @(negedge clk50);
      n++;
    end
    check("rd_gnt_seen", 32'(n < 40), 1);
    bus.rd_req = 1'b0;
    if (n < 40) begin
      want = solo ? exp : shadow[a];
      check("rd_addr_pins", sram_addr, a);
      for (int c = 0; c < 4; c++) begin
        if (!oe_n) oe++;
        if (bus.rd_valid) begin
          vcnt++;
          if (vat < 0) begin vat = c; got = bus.rd_data; end
        end
        if (c == 1) check("rd_gnt_pulse", bus.rd_gnt, 0);
        @(negedge clk50);
      end
      check("rd_valid_lat", vat, 2);
      check("rd_valid_cnt", vcnt, 1);
      check("rd_data", got, want);
      if (solo) check("rd_oe_cycles", oe, 2);
    end
  endtask

  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    be;
    logic [15:0]   exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, g, last, gap_bad, mism;
    logic [9:0] order;

    for (int i = 0; i < 16; i++) begin mem[i] = '0; shadow[i] = '0; end
    bus.rd_req = 0; bus.rd_addr = '0; bus.wr_req = 0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.wr_be = '0;

    vecs[0]  = '{1'b1, 4'h3, 16'hFFFF, 2'b11, 16'h0000};
    vecs[1]  = '{1'b1, 4'h3, 16'h12AB, 2'b01, 16'h0000};
    vecs[2]  = '{1'b0, 4'h3, 16'h0000, 2'b00, 16'hFFAB};
    vecs[3]  = '{1'b1, 4'h5, 16'hBEEF, 2'b11, 16'h0000};
    vecs[4]  = '{1'b0, 4'h5, 16'h0000, 2'b00, 16'hBEEF};
    vecs[5]  = '{1'b1, 4'h0, 16'h1234, 2'b10, 16'h0000};
    vecs[6]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 16'h1200};
    vecs[7]  = '{1'b1, 4'hF, 16'hCAFE, 2'b00, 16'h0000};
    vecs[8]  = '{1'b0, 4'hF, 16'h0000, 2'b00, 16'h0000};
    vecs[9]  = '{1'b1, 4'hF, 16'h5A5A, 2'b11, 16'h0000};
    vecs[10] = '{1'b0, 4'hF, 16'h0000, 2'b00, 16'h5A5A};
    vecs[11] = '{1'b0, 4'h3, 16'h0000, 2'b00, 16'hFFAB};

    // reset state
    repeat (3) @(negedge clk50);
    check("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    check("rst_addr", sram_addr, 0);
    check("rst_dq_z", sram_dq, PROBE);
    check("rst_pulses", {bus.rd_gnt, bus.wr_gnt, bus.rd_valid}, 0);
    check("rst_rd_data", bus.rd_data, 0);
`ifdef SRAM_ARB_CLEAR_EN
    check("rst_init_done", bus.init_done, 0);
`else
    check("rst_init_done", bus.init_done, 1);
`endif
    log_addr.delete(); log_data.delete();
    rst = 1'b0;

`ifdef SRAM_ARB_CLEAR_EN
    begin
      int first = -1, gnt_early = 0, we_odd = 0, we_cnt = 0;
      for (int c = 0; c < 36; c++) begin
        @(negedge clk50);
        if (!bus.init_done && (bus.rd_gnt || bus.wr_gnt)) gnt_early++;
        if (!we_n) begin we_cnt++; if (c % 2 == 1) we_odd++; end
        if (bus.init_done && first < 0) first = c;
      end
      check("clr_init_rise", first, 32);
      check("clr_no_gnt", gnt_early, 0);
      check("clr_we_even_only", we_odd, 0);
      check("clr_we_count", we_cnt, 16);
      check("clr_log_size", log_addr.size(), 16);
      mism = 0;
      for (int i = 0; i < log_addr.size(); i++)
        if (log_addr[i] != AW'(i) || log_data[i] != 16'h0000) mism++;
      check("clr_log_content", mism, 0);
    end
`else
    @(negedge clk50);
    check("init_done_high", bus.init_done, 1);
`endif

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].be, 1'b0);
      else               do_read(vecs[i].addr, vecs[i].exp, 1'b1);
    end

    // idle bus
    repeat (2) @(negedge clk50);
    for (int c = 0; c < 10; c++) begin
      check("idle_strobes", {ce_n, oe_n, we_n}, 3'b111);
      check("idle_dq_z", sram_dq, PROBE);
      check("idle_pulses", {bus.rd_gnt, bus.wr_gnt, bus.rd_valid}, 0);
      @(negedge clk50);
    end

    // both requesters held: reads limited to BURST in a row, no idle gaps
    bus.rd_req = 1; bus.rd_addr = 4'h7;
    bus.wr_req = 1; bus.wr_addr = 4'h9; bus.wr_data = 16'h7777; bus.wr_be = 2'b11;
    order = '0; g = 0; last = -1; gap_bad = 0; n = 0;
    while (g < 10 && n < 60) begin
      @(negedge clk50);
      n++;
      if (bus.rd_gnt || bus.wr_gnt) begin
        if (bus.wr_gnt) begin order[g] = 1'b1; shadow_write(4'h9, 16'h7777, 2'b11); end
        if (last >= 0 && n - last != 2) gap_bad++;
        last = n;
        g++;
      end
    end
    bus.rd_req = 0; bus.wr_req = 0;
    check("starve_count", g, 10);
    check("starve_order", order, 10'h210);
    check("starve_gaps", gap_bad, 0);
    repeat (4) @(negedge clk50);

    // randomized concurrent traffic
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk50);
          do_read(AW'($urandom_range(0, 15)), 16'h0000, 1'b0);
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk50);
          do_write(AW'($urandom_range(0, 15)), 16'($urandom), 2'($urandom_range(0, 3)), 1'b1);
        end
      end
    join
    repeat (4) @(negedge clk50);

    for (int i = 0; i < 16; i++) check($sformatf("mem_word_%0d", i), mem[i], shadow[i]);

    // reset during WR_A
    bus.wr_req = 1; bus.wr_addr = 4'h2; bus.wr_data = 16'hDEAD; bus.wr_be = 2'b11;
    n = 0;
    @(negedge clk50);
    while (!bus.wr_gnt && n < 40) begin @(negedge clk50); n++; end
    check("rstw_gnt_seen", 32'(n < 40), 1);
    check("rstw_in_wr_a", we_n, 0);
    rst = 1'b1; bus.wr_req = 0;
    log_addr.delete(); log_data.delete();
    @(negedge clk50);
    check("rstw_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'h1F);
    check("rstw_dq_z", sram_dq, PROBE);
    check("rstw_pulses", {bus.rd_gnt, bus.wr_gnt, bus.rd_valid}, 0);
    check("rstw_no_write", log_addr.size(), 0);
    rst = 1'b0;
`ifdef SRAM_ARB_CLEAR_EN
    repeat (36) @(negedge clk50);
    check("rstw_sweep_size", log_addr.size(), 16);
    if (log_addr.size() > 0) check("rstw_sweep_start", log_addr[0], 0);
    check("rstw_init_done", bus.init_done, 1);
`else
    for (int c = 0; c < 3; c++) begin
      @(negedge clk50);
      check("rstw_after", {bus.wr_gnt, bus.rd_valid, we_n}, 3'b001);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
